rename_freelist: RTL and testbench

RENAME_FREELIST -- requirements
Module: rename_freelist

---
 rtl/rename_freelist.sv | 98 +++++++++
 tb/tb_rename_freelist.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rename_freelist.sv
// Physical-register free list for rename: circular tag FIFO with a speculative allocation
// head, a retirement head used to restore on flush, and a tail where released tags are written.
module rename_freelist #(
  parameter  int PREG_NUM = 128,
  parameter  int AREG_NUM = 64,
  localparam int TAG_W    = $clog2(PREG_NUM),
  localparam int FL_DEPTH = PREG_NUM - AREG_NUM,
  localparam int IDX_W    = $clog2(FL_DEPTH),
  localparam int PTR_W    = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             commit_valid,
  input  logic             commit_alloc,
  input  logic [TAG_W-1:0] commit_P_rd_old,
  input  logic             flush,
  output logic [PTR_W-1:0] free_count,
  output logic             overflow_err
);

  logic [TAG_W-1:0] entry [FL_DEPTH];
  logic [PTR_W-1:0] spec_head;
  logic [PTR_W-1:0] retire_head;
  logic [PTR_W-1:0] tail;

  logic [PTR_W-1:0] spec_head_nxt;
  logic [PTR_W-1:0] retire_head_nxt;
  logic [PTR_W-1:0] occupancy;
  logic             alloc_fire;
  logic             retire_fire;
  logic             release_req;
  logic             retire_vacates;
  logic             list_full;
  logic             release_fire;
  logic             release_drop;

  // Wrap bit toggles naturally when the index rolls over because the depth is a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] ptr_idx(input logic [PTR_W-1:0] p);
    return p[IDX_W-1:0];
  endfunction

  assign free_count  = tail - spec_head;
  assign alloc_ready = (free_count != '0);
  assign alloc_tag   = entry[ptr_idx(spec_head)];
  assign occupancy   = tail - retire_head;

  assign alloc_fire  = alloc_req && alloc_ready && !flush;
  assign retire_fire = commit_valid && commit_alloc;
  assign release_req = retire_fire && (commit_P_rd_old != '0);

  // A retire frees the slot at retire_head only if that slot was actually handed out;
  // otherwise a full array has no room and the release would overwrite a free tag.
  assign retire_vacates = retire_fire && (retire_head != spec_head);
  assign list_full      = (occupancy == PTR_W'(FL_DEPTH));
  assign release_drop   = release_req && list_full && !retire_vacates;
  assign release_fire   = release_req && !release_drop;

  assign retire_head_nxt = retire_fire ? ptr_inc(retire_head) : retire_head;

  always_comb begin
    spec_head_nxt = spec_head;
    if (flush) begin
      spec_head_nxt = retire_head_nxt;
    end else if (alloc_fire) begin
      spec_head_nxt = ptr_inc(spec_head);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_head    <= '0;
      retire_head  <= '0;
      tail         <= PTR_W'(FL_DEPTH);
      overflow_err <= 1'b0;
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry[i] <= TAG_W'(AREG_NUM + i);
      end
    end else begin
      spec_head   <= spec_head_nxt;
      retire_head <= retire_head_nxt;
      if (release_fire) begin
        entry[ptr_idx(tail)] <= commit_P_rd_old;
        tail                 <= ptr_inc(tail);
      end
      if (release_drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rename_freelist.sv
// Bench for rename_freelist: directed scenarios plus random traffic checked every cycle
// against a queue model (free tags queue + in-flight allocation queue).
module tb_rename_freelist;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic       alloc_ready;
  logic [6:0] alloc_tag;
  logic       commit_valid;
  logic       commit_alloc;
  logic [6:0] commit_P_rd_old;
  logic       flush;
  logic [6:0] free_count;
  logic       overflow_err;

  int n_chk  = 0;
  int n_fail = 0;

  int freeq[$];
  int inflight[$];
  bit m_ovf;

  always #5 clk = ~clk;

  rename_freelist dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_req       (alloc_req),
    .alloc_ready     (alloc_ready),
    .alloc_tag       (alloc_tag),
    .commit_valid    (commit_valid),
    .commit_alloc    (commit_alloc),
    .commit_P_rd_old (commit_P_rd_old),
    .flush           (flush),
    .free_count      (free_count),
    .overflow_err    (overflow_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    freeq.delete();
    inflight.delete();
    for (int t = 64; t < 128; t++) freeq.push_back(t);
    m_ovf = 1'b0;
  endtask

  task automatic compare_outputs();
    chk("free_count", int'(free_count), freeq.size());
    chk("alloc_ready", int'(alloc_ready), int'(freeq.size() != 0));
    if (freeq.size() != 0) chk("alloc_tag", int'(alloc_tag), freeq[0]);
    chk("overflow_err", int'(overflow_err), int'(m_ovf));
  endtask

  task automatic model_step(input bit a, input bit cv, input bit ca, input int p, input bit fl);
    bit ready;
    bit full;
    int rel;
    ready = (freeq.size() != 0);
    full  = (freeq.size() == 64);
    rel   = -1;
    if (cv && ca) begin
      if (inflight.size() != 0) void'(inflight.pop_front());
      if (p != 0) begin
        if (full) m_ovf = 1'b1;
        else      rel = p;
      end
    end
    if (a && ready && !fl) inflight.push_back(freeq.pop_front());
    if (rel >= 0) freeq.push_back(rel);
    if (fl) begin
      freeq = {inflight, freeq};
      inflight.delete();
    end
  endtask

  // One clock: drive, check pre-edge outputs at negedge, advance model at posedge.
  task automatic cyc(input bit a, input bit cv, input bit ca, input int p, input bit fl);
    alloc_req       = a;
    commit_valid    = cv;
    commit_alloc    = ca;
    commit_P_rd_old = 7'(p);
    flush           = fl;
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_step(a, cv, ca, p, fl);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_req = 1'b1;
    commit_valid = 1'b1;
    commit_alloc = 1'b1;
    commit_P_rd_old = 7'd9;
    flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    alloc_req = 1'b0;
    commit_valid = 1'b0;
    commit_alloc = 1'b0;
    commit_P_rd_old = '0;
    flush = 1'b0;
    @(posedge clk);
    do_reset();

    // Reset state, then drain the list in order 64..127.
    chk("rst_tag", int'(alloc_tag), 64);
    chk("rst_count", int'(free_count), 64);
    for (int i = 0; i < 64; i++) begin
      chk("drain_tag", int'(alloc_tag), 64 + i);
      cyc(1, 0, 0, 0, 0);
    end
    chk("empty_ready", int'(alloc_ready), 0);
    cyc(1, 0, 0, 0, 0);
    chk("empty_count", int'(free_count), 0);

    // Release into an empty list with a same-cycle alloc request.
    cyc(1, 1, 1, 5, 0);
    chk("rel_ready", int'(alloc_ready), 1);
    chk("rel_tag", int'(alloc_tag), 5);
    cyc(0, 0, 0, 0, 0);

    // Alloc three, retire one with release and flush together.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 10, 1);
    chk("flush_tag", int'(alloc_tag), 65);
    chk("flush_ovf", int'(overflow_err), 0);
    cyc(0, 0, 0, 0, 0);

    // Release into a full list is dropped and sets the sticky error.
    do_reset();
    cyc(0, 1, 1, 7, 0);
    chk("ovf_set", int'(overflow_err), 1);
    chk("ovf_count", int'(free_count), 64);
    chk("ovf_tag", int'(alloc_tag), 64);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_sticky", int'(overflow_err), 1);
    do_reset();
    chk("ovf_clear", int'(overflow_err), 0);

    // Retire without release leaves the free count alone.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("zero_rel_count", int'(free_count), 62);
    cyc(0, 0, 0, 0, 0);

    // Alternate alloc and release of the same tag across the index wrap.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        t = int'(alloc_tag);
        cyc(1, 0, 0, 0, 0);
      end else begin
        cyc(0, 1, 1, t, 0);
      end
      chk("wrap_range", int'(free_count >= 7'd63 && free_count <= 7'd64), 1);
    end

    // Random traffic; commits only when there is an in-flight allocation to retire.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit a, cv, fl;
      int p;
      a  = ($urandom % 4) != 0;
      cv = (inflight.size() != 0) && (($urandom % 3) == 0);
      p  = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 127));
      fl = ($urandom % 25) == 0;
      cyc(a, cv, cv, p, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
